// File: rtl/xrdport_if.sv
// Stream-side handshake bundle for xrdport.
// The master end is the read port, which produces FWFT data.
// The slave end is the downstream consumer.
interface xrdport_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              ready_i;

  modport master (output data_o, output valid_o, input ready_i);
  modport slave  (input data_o, input valid_o, output ready_i);
endinterface

// File: rtl/xrdport.sv
// xrdport: read port between an address generator and a synchronous RAM.
//
// - Read requests are issued to the RAM.
// - The returning data is buffered in a small FWFT FIFO.
// - The data is presented as a valid/ready stream.
//
// Credit-based stall: the generator is paused when the buffered words plus
// the in-flight read would use up the FIFO. Because of this, a push can never
// find the FIFO full.
//
// Optional feature: define XRDPORT_STALL_CNT_EN to add stall_cnt_o. This is a
// saturating 16-bit count of request cycles that were stalled by pause_o.
module xrdport #(
  parameter int MEM_ADDR_W = 10,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clear_i,
  input  logic [MEM_ADDR_W-1:0] addr_i,
  input  logic                  mem_en_i,
  input  logic                  done_i,
  output logic                  pause_o,
  output logic                  mem_en_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0]     mem_data_i,
  xrdport_if.master             strm_if,
  output logic                  done_o
`ifdef XRDPORT_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] PAUSE_LVL = (CNT_W + 1)'(FIFO_DEPTH - 1);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_rd_pend;

  logic [CNT_W:0]    w_inflight;
  logic              w_pause;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;

  // Stall the generator from registered state only: buffered + in-flight words.
  always_comb begin
    w_inflight = {1'b0, r_count} + {{CNT_W{1'b0}}, r_rd_pend};
    w_pause    = (w_inflight >= PAUSE_LVL);
  end

  // RAM request path and the stream/handshake decodes.
  always_comb begin
    mem_en_o   = mem_en_i & ~w_pause & ~clear_i;
    mem_addr_o = addr_i;
    pause_o    = w_pause;
    w_valid    = (r_count != '0);
    w_push     = r_rd_pend & ~clear_i;
    w_pop      = w_valid & strm_if.ready_i & ~clear_i;
    done_o     = done_i & (r_count == '0) & ~r_rd_pend;
  end

  // Drive the FWFT head directly from storage at the read pointer.
  always_comb begin
    strm_if.valid_o = w_valid;
    strm_if.data_o  = r_mem[r_rd_ptr];
  end

  // Track which cycle carries valid RAM read data.
  // Clear drops it, because mem_en_o is gated by clear_i.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= mem_en_o;
    end
  end

  // FIFO pointers and occupancy.
  // Clear wins over a push or pop in the same cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Write returning RAM data into storage. The storage itself has no reset.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= mem_data_i;
    end
  end

`ifdef XRDPORT_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Count requests held off by pause_o, saturating at all-ones.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_stall_cnt <= '0;
    end else if (clear_i) begin
      r_stall_cnt <= '0;
    end else if (mem_en_i && w_pause && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
